// File: rtl/crc_xor_stream.sv
// rtl/crc_xor_stream.sv - streaming CRC/parity engine with valid/ready beats
//
// Folds DATA_W-bit beats into a CRC_W-bit remainder using generator POLY
// (implicit top bit omitted), preset INIT, and final XOROUT. One checksum is
// produced per message, delimited by a start pulse and a beat with in_last.
// With CRC_W=1 and POLY=1 it reduces to a running parity of all input bits.
//
// Optional build macro: CRC_XOR_REFLECT_EN
//   defined   : beats are consumed LSB-first and the final remainder is
//               bit-reversed across CRC_W bits before XOROUT is applied.
//   undefined : beats are consumed MSB-first, no output reversal.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      one-cycle pulse, begins (or restarts) a message
//   in_valid   source presents a beat
//   in_ready   engine accepts a beat (RUN and no start this cycle)
//   in_data    beat payload, DATA_W bits
//   in_last    marks the final beat of a message
//   out_valid  checksum available, held until out_ready
//   out_ready  sink takes the checksum
//   out_crc    final checksum, CRC_W bits

module crc_xor_stream #(
    parameter int               DATA_W = 8,
    parameter int               CRC_W  = 8,
    parameter logic [CRC_W-1:0] POLY   = 8'h07,
    parameter logic [CRC_W-1:0] INIT   = '0,
    parameter logic [CRC_W-1:0] XOROUT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  out_crc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CRC_W-1:0]   crc_reg;
    logic [CRC_W-1:0]   crc_next;
    logic [CRC_W-1:0]   crc_step;
    logic [CRC_W-1:0]   out_crc_next;
    logic               out_valid_next;

    // Bit-serial division unrolled over the whole beat. The data word is
    // shifted rather than indexed so every select stays constant.
    function automatic logic [CRC_W-1:0] step(input logic [CRC_W-1:0] crc_in,
                                              input logic [DATA_W-1:0] data);
        logic [CRC_W-1:0]  c;
        logic [DATA_W-1:0] d;
        logic              fb;
        c = crc_in;
        d = data;
        for (int i = 0; i < DATA_W; i++) begin
`ifdef CRC_XOR_REFLECT_EN
            fb = c[CRC_W-1] ^ d[0];
            d  = d >> 1;
`else
            fb = c[CRC_W-1] ^ d[DATA_W-1];
            d  = d << 1;
`endif
            // For CRC_W=1 the shift leaves zero, so c becomes fb (POLY=1).
            c = c << 1;
            if (fb) begin
                c = c ^ POLY;
            end
        end
        return c;
    endfunction

    function automatic logic [CRC_W-1:0] finalize(input logic [CRC_W-1:0] crc_in);
`ifdef CRC_XOR_REFLECT_EN
        logic [CRC_W-1:0] c;
        logic [CRC_W-1:0] r;
        c = crc_in;
        r = '0;
        for (int i = 0; i < CRC_W; i++) begin
            r    = r << 1;
            r[0] = c[0];
            c    = c >> 1;
        end
        return r ^ XOROUT;
`else
        return crc_in ^ XOROUT;
`endif
    endfunction

    always_comb begin
        state_next     = state;
        crc_next       = crc_reg;
        out_crc_next   = out_crc;
        out_valid_next = out_valid;
        in_ready       = 1'b0;
        crc_step       = step(crc_reg, in_data);

        case (state)
            IDLE: begin
                if (start) begin
                    crc_next   = INIT;
                    state_next = RUN;
                end
            end
            RUN: begin
                // start wins over a beat offered in the same cycle: the
                // partial message is dropped and the beat is refused.
                in_ready = !start;
                if (start) begin
                    crc_next = INIT;
                end else if (in_valid) begin
                    crc_next = crc_step;
                    if (in_last) begin
                        out_crc_next   = finalize(crc_step);
                        out_valid_next = 1'b1;
                        state_next     = DONE;
                    end
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            crc_reg   <= INIT;
            out_valid <= 1'b0;
            out_crc   <= '0;
        end else begin
            state     <= state_next;
            crc_reg   <= crc_next;
            out_valid <= out_valid_next;
            out_crc   <= out_crc_next;
        end
    end

endmodule

// File: tb/tb_crc_xor_stream.sv
// tb/tb_crc_xor_stream.sv - scoreboard bench for crc_xor_stream (parity, CRC-8/16/32)

module tb_crc_xor_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_ready;

    logic        rdy8, rdy16, rdy32, rdy1;
    logic        ov8, ov16, ov32, ov1;
    logic [7:0]  crc8;
    logic [15:0] crc16;
    logic [31:0] crc32;
    logic [0:0]  crc1;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp8[$];
    logic [31:0] exp16[$];
    logic [31:0] exp32[$];
    logic [31:0] exp1[$];

    logic [31:0] lat8, lat16, lat32, lat1;

    always #5 clk = ~clk;

    crc_xor_stream u8 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy8),
        .in_data(in_data), .in_last(in_last), .out_valid(ov8), .out_ready(out_ready),
        .out_crc(crc8)
    );

    crc_xor_stream #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOROUT(16'h0000)) u16 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy16),
        .in_data(in_data), .in_last(in_last), .out_valid(ov16), .out_ready(out_ready),
        .out_crc(crc16)
    );

    crc_xor_stream #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
                     .XOROUT(32'hFFFFFFFF)) u32 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy32),
        .in_data(in_data), .in_last(in_last), .out_valid(ov32), .out_ready(out_ready),
        .out_crc(crc32)
    );

    crc_xor_stream #(.DATA_W(2), .CRC_W(1), .POLY(1'b1), .INIT(1'b0), .XOROUT(1'b0)) u1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data[1:0]), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
        .out_crc(crc1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: polynomial division over the message bit stream, done with
    // plain integer arithmetic on a w-bit remainder.
    function automatic logic [31:0] crc_model(input byte unsigned msg[$], input int w,
                                              input longint unsigned poly,
                                              input longint unsigned init,
                                              input longint unsigned xorout);
        longint unsigned mask;
        longint unsigned top;
        longint unsigned c;
        longint unsigned r;
        int unsigned     b;
        int unsigned     rb;
        bit              fbit;
        mask = (64'd1 << w) - 64'd1;
        top  = 64'd1 << (w - 1);
        c    = init & mask;
        foreach (msg[k]) begin
            b = msg[k];
`ifdef CRC_XOR_REFLECT_EN
            rb = 0;
            for (int j = 0; j < 8; j++) rb = rb * 2 + ((b >> j) & 1);
            b = rb;
`endif
            for (int j = 7; j >= 0; j--) begin
                fbit = ((b >> j) & 1) != 0;
                if (((c & top) != 0) != fbit) c = ((c << 1) & mask) ^ poly;
                else                           c = (c << 1) & mask;
            end
        end
`ifdef CRC_XOR_REFLECT_EN
        r = 0;
        for (int j = 0; j < w; j++) r = r * 2 + ((c >> j) & 64'd1);
        c = r;
`endif
        return 32'((c ^ xorout) & mask);
    endfunction

    function automatic logic [31:0] parity_model(input byte unsigned msg[$]);
        int ones;
        ones = 0;
        foreach (msg[k]) ones += $countones(msg[k] & 8'h03);
        return 32'(ones % 2);
    endfunction

    // Monitor: every checksum handshake pops the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (ov8 && out_ready) begin
                if (exp8.size() == 0) check("sb8_unexpected", 32'd1, 32'd0);
                else check("sb_crc8", 32'(crc8), exp8.pop_front());
            end
            if (ov16 && out_ready) begin
                if (exp16.size() == 0) check("sb16_unexpected", 32'd1, 32'd0);
                else check("sb_crc16", 32'(crc16), exp16.pop_front());
            end
            if (ov32 && out_ready) begin
                if (exp32.size() == 0) check("sb32_unexpected", 32'd1, 32'd0);
                else check("sb_crc32", crc32, exp32.pop_front());
            end
            if (ov1 && out_ready) begin
                if (exp1.size() == 0) check("sb1_unexpected", 32'd1, 32'd0);
                else check("sb_parity", 32'(crc1), exp1.pop_front());
            end
        end
    end

    task automatic start_pulse();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input byte unsigned d, input bit last);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rdy8) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("beat_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // mode: 0 = sink always ready, 1 = random sink stalls, 2 = sink held off
    task automatic send_msg(input byte unsigned msg[$], input bit gaps, input int mode,
                            input bit do_start);
        if (do_start) start_pulse();
        exp8.push_back(crc_model(msg, 8, 64'h07, 64'h0, 64'h0));
        exp16.push_back(crc_model(msg, 16, 64'h1021, 64'hFFFF, 64'h0));
        exp32.push_back(crc_model(msg, 32, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF));
        exp1.push_back(parity_model(msg));
        out_ready = (mode == 0);
        foreach (msg[k]) begin
            send_beat(msg[k], k == msg.size() - 1);
            if (gaps && k != msg.size() - 1) begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        check("latency_out_valid", 32'({ov8, ov16, ov32, ov1}), 32'hF);
        lat8  = 32'(crc8);
        lat16 = 32'(crc16);
        lat32 = crc32;
        lat1  = 32'(crc1);
        if (mode != 2) begin
            for (int k = 0; k < 40 && ov8; k++) begin
                @(posedge clk); #1;
                out_ready = (mode == 0 || k >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            check("drain_out_valid", 32'(ov8), 32'd0);
            out_ready = 1'b1;
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp8.delete();
        exp16.delete();
        exp32.delete();
        exp1.delete();
    endtask

    byte unsigned vec[$];
    byte unsigned rmsg[$];
    byte unsigned one[$];
    logic [3:0]   ptab;
    logic [31:0]  bp_exp;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) vec.push_back(8'(8'h31 + i));

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'({ov8, ov16, ov32, ov1}), 32'h0);
        check("reset_in_ready", 32'({rdy8, rdy16, rdy32, rdy1}), 32'h0);
        check("reset_crc8", 32'(crc8), 32'h0);
        check("reset_crc32", crc32, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // IDLE refuses beats
        in_valid = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(rdy8), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Parity: single-beat messages 00, 01, 10, 11
        ptab = 4'b0110;
        for (int v = 0; v < 4; v++) begin
            one.delete();
            one.push_back(8'(v));
            send_msg(one, 1'b0, 0, 1'b1);
            check("parity_value", lat1, 32'((ptab >> v) & 4'd1));
        end

        // Check vector "123456789", gap-free then with idle cycles between beats
        send_msg(vec, 1'b0, 0, 1'b1);
`ifdef CRC_XOR_REFLECT_EN
        check("crc32_check_value", lat32, 32'hCBF43926);
`else
        check("crc8_check_value", lat8, 32'hF4);
        check("crc16_check_value", lat16, 32'h29B1);
        check("crc32_check_value", lat32, 32'hFC891918);
`endif
        send_msg(vec, 1'b1, 0, 1'b1);
`ifndef CRC_XOR_REFLECT_EN
        check("crc16_gapped", lat16, 32'h29B1);
        check("crc8_gapped", lat8, 32'hF4);
`endif

        // Backpressure: sink held off for 3 cycles, start must be ignored
        bp_exp = crc_model(vec, 8, 64'h07, 64'h0, 64'h0);
        send_msg(vec, 1'b0, 2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            start = (i == 1);
            @(negedge clk);
            check("bp_out_valid", 32'(ov8), 32'd1);
            check("bp_crc_stable", 32'(crc8), bp_exp);
            check("bp_in_ready", 32'(rdy8), 32'd0);
        end
        @(posedge clk); #1;
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_idle_out_valid", 32'(ov8), 32'd0);
        check("bp_idle_in_ready", 32'(rdy8), 32'd0);
        check("bp_crc_kept", 32'(crc8), bp_exp);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Restart after 4 beats; the beat offered alongside start is refused
        start_pulse();
        for (int i = 0; i < 4; i++) send_beat(vec[i], 1'b0);
        start    = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        check("restart_in_ready", 32'(rdy8), 32'd0);
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        send_msg(vec, 1'b0, 0, 1'b0);
`ifndef CRC_XOR_REFLECT_EN
        check("restart_crc8", lat8, 32'hF4);
`endif

        // Reset after 5 accepted beats
        start_pulse();
        for (int i = 0; i < 5; i++) send_beat(vec[i], 1'b0);
        reset_pulse();
        @(negedge clk);
        check("rst_mid_out_valid", 32'(ov8), 32'd0);
        check("rst_mid_crc8", 32'(crc8), 32'd0);
        check("rst_mid_in_ready", 32'(rdy8), 32'd0);
        send_msg(vec, 1'b0, 0, 1'b1);
        check("rst_mid_fresh_crc8", lat8, crc_model(vec, 8, 64'h07, 64'h0, 64'h0));

        // Reset with a checksum pending
        send_msg(vec, 1'b0, 2, 1'b1);
        reset_pulse();
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_pend_out_valid", 32'(ov8), 32'd0);
        check("rst_pend_crc16", 32'(crc16), 32'd0);

        // Randomized messages, gaps and sink stalls
        for (int n = 0; n < 40; n++) begin
            rmsg.delete();
            for (int i = 0; i < $urandom_range(1, 8); i++) rmsg.push_back(8'($urandom));
            send_msg(rmsg, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb_empty", 32'(exp8.size() + exp16.size() + exp32.size() + exp1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/crc_xor_stream.md
Name: crc_xor_stream

Overview:
- Parametrised streaming CRC/parity engine. Successor to the single-gate XOR: folds multi-bit input words into a CRC_W-bit remainder with a configurable XOR polynomial.
- Accepts one DATA_W-bit beat per cycle over a valid/ready handshake. Produces one checksum per message.
- Sits between a word source and a checker/appender. With CRC_W=1 and POLY=1 it degenerates to a running XOR (parity) of all input bits.

Parameters:
- DATA_W, 8, input beat width in bits; legal range 1 or more.
- CRC_W, 8, remainder width; legal range 1..32.
- POLY, 8'h07, generator polynomial, CRC_W bits, implicit top bit omitted.
- INIT, 0, remainder preset loaded on start.
- XOROUT, 0, constant XORed into the final remainder.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new message.
- in_valid  in  1  source has a beat.
- in_ready  out  1  engine accepts a beat.
- in_data  in  DATA_W  beat payload.
- in_last  in  1  qualifies the final beat of a message.
- out_valid  out  1  checksum available.
- out_ready  in  1  sink takes the checksum.
- out_crc  out  CRC_W  final checksum.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk, and has priority over every other input.
- Reset values: state=IDLE, crc_reg=INIT, out_valid=0, out_crc=0. in_ready=0, since it is derived from state.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 -> crc_reg<=INIT, go to RUN.
  - Beats presented while in IDLE are not accepted.
- RUN:
  - in_ready = !start. This is combinational on start; all other terms are registered.
  - A beat is accepted when in_valid & in_ready.
  - An accepted beat sets crc_reg <= step(crc_reg, in_data).
  - An accepted beat with in_last=1 additionally sets out_crc <= step(...) ^ XOROUT and out_valid<=1, and moves to DONE.
  - Latency: last beat accepted in cycle N -> out_valid=1 in cycle N+1.
- step(): DATA_W serial iterations within one cycle, MSB of in_data first. Each iteration:
  - fb = crc[CRC_W-1] ^ bit.
  - crc = (crc << 1, truncated to CRC_W) ^ (fb ? POLY : 0).
  - For CRC_W=1 the shift yields 0, so crc = fb.
- DONE:
  - in_ready=0.
  - out_valid is held and out_crc is stable until out_ready=1.
  - On out_valid & out_ready: out_valid<=0, go to IDLE. out_crc keeps its last value.
  - start is ignored in DONE.
- Boundaries:
  - start in RUN: the partial message is discarded, crc_reg<=INIT, state stays RUN. A beat offered in the same cycle is not accepted (in_ready=0).
  - in_valid=0 cycles in RUN: crc_reg holds and there is no timeout.
  - Single-beat message (in_last on the first beat) is legal.
  - rst in any state returns to the reset values on the next edge, including mid-message and with out_valid pending. The pending checksum is lost.
  - in_data and in_last are don't-care when the beat is not accepted.

Optional Feature:
- Macro: CRC_XOR_REFLECT_EN.
- Defined:
  - step() consumes in_data LSB-first.
  - The final remainder is bit-reversed across CRC_W bits before the XOROUT XOR.
  - crc_reg itself is never reversed.
- Undefined: MSB-first processing and no output reversal. Ports and timing are identical in both builds.

Test Plan:
- Parity (DATA_W=2, CRC_W=1, POLY=1, INIT=0): four single-beat messages with in_data=00,01,10,11 -> out_crc = 0,1,1,0, each one cycle after its beat.
- CRC-8 with default parameters: ASCII "123456789" (0x31..0x39), 9 beats, in_last on 0x39 -> out_crc=8'hF4.
- CRC-16 (CRC_W=16, POLY=16'h1021, INIT=16'hFFFF, XOROUT=0), same 9 beats with in_valid toggled 1,0 between beats -> out_crc=16'h29B1, identical to the gap-free run.
- CRC-32 with CRC_XOR_REFLECT_EN defined (CRC_W=32, POLY=32'h04C11DB7, INIT=XOROUT=32'hFFFFFFFF), "123456789" -> out_crc=32'hCBF43926.
- Backpressure and restart:
  - Hold out_ready=0 for 3 cycles after out_valid -> out_valid and out_crc stay stable, in_ready=0, start ignored.
  - Then out_ready=1 -> IDLE next cycle.
  - Separately, start after 4 beats of "123456789" and then send the full 9 beats -> 8'hF4.
- Reset mid-operation: rst=1 after 5 accepted beats -> next cycle state IDLE, out_valid=0, out_crc=0, in_ready=0. A fresh message afterwards yields the correct CRC.
